// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
// Contents:
//   KIND_*        entry kind encoding carried on alloc_kind_i / commit_kind_o
//   OPC_*         RV32I major opcodes, used upstream to derive the entry kind
//   rob_entry_t   per-entry storage record
//   kind_ends_group / kind_from_opcode  status helpers
package rob_pkg;

  localparam logic [2:0] KIND_NORMAL = 3'd0;
  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_JALR   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [2:0] KIND_LOAD   = 3'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [2:0]  kind;
    logic [4:0]  dest;
    logic [31:0] value;
  } rob_entry_t;

  // Branches, jalr and stores must be the last retirement of a cycle so the
  // front end / memory side sees them one at a time.
  function automatic logic kind_ends_group(input logic [2:0] kind);
    return (kind == KIND_BRANCH) || (kind == KIND_JALR) || (kind == KIND_STORE);
  endfunction

  function automatic logic [2:0] kind_from_opcode(input logic [6:0] opcode);
    logic [2:0] k;
    case (opcode)
      OPC_BRANCH: k = KIND_BRANCH;
      OPC_JALR:   k = KIND_JALR;
      OPC_STORE:  k = KIND_STORE;
      OPC_LOAD:   k = KIND_LOAD;
      default:    k = KIND_NORMAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// In-order retirement selector (purely combinational).
// Ports:
//   head_i    oldest entry index
//   count_i   occupied entries
//   done_i    per-entry registered done flag
//   kind_i    per-entry kind, packed 3 bits per entry
//   retire_o  per-slot retire mask (slot k <-> entry head+k)
//   n_o       number of entries retired this cycle
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int COMMIT_W = 2,
  parameter int N_W      = $clog2(COMMIT_W + 1)
) (
  input  logic [IDX_W-1:0]   head_i,
  input  logic [IDX_W:0]     count_i,
  input  logic [DEPTH-1:0]   done_i,
  input  logic [DEPTH*3-1:0] kind_i,
  output logic [COMMIT_W-1:0] retire_o,
  output logic [N_W-1:0]     n_o
);

  logic             open;
  logic [IDX_W-1:0] idx;

  // A slot retires only if every older slot retired and no group-ending
  // kind has been seen yet.
  always_comb begin
    retire_o = '0;
    n_o      = '0;
    open     = 1'b1;
    idx      = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx = head_i + IDX_W'(k);
      if (open && (count_i > (IDX_W+1)'(k)) && done_i[idx]) begin
        retire_o[k] = 1'b1;
        n_o         = N_W'(k + 1);
        if (kind_ends_group(kind_i[idx*3 +: 3])) open = 1'b0;
      end else begin
        open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Parametrised reorder buffer with multi-port writeback and multi-slot commit.
// Ports:
//   clk_i, rst_ni, rdy_i            clock, async active-low reset, global enable
//   alloc_*_i / alloc_tag_o         in-order allocation, tag = current tail
//   rob_full_o                      count >= DEPTH-FULL_MARGIN
//   wb_valid_i/wb_tag_i/wb_value_i  NUM_WB out-of-order completion ports
//   query_tag_i/query_ready_o/query_value_o  two lookup ports with wb bypass
//   flush_i                         empty the buffer
//   commit_*_o                      registered retirement bus, COMMIT_W slots
//   rob_head_o                      head as of the previous cycle
//   count_o                         occupied entries
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int NUM_WB      = 4,
  parameter int COMMIT_W    = 2,
  parameter int FULL_MARGIN = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rdy_i,
  input  logic                     alloc_valid_i,
  input  logic [4:0]               alloc_dest_i,
  input  logic [2:0]               alloc_kind_i,
  input  logic                     alloc_value_valid_i,
  input  logic [31:0]              alloc_value_i,
  output logic [IDX_W-1:0]         alloc_tag_o,
  output logic                     rob_full_o,
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0]  wb_tag_i,
  input  logic [NUM_WB*32-1:0]     wb_value_i,
  input  logic [2*IDX_W-1:0]       query_tag_i,
  output logic [1:0]               query_ready_o,
  output logic [63:0]              query_value_o,
  input  logic                     flush_i,
  output logic [COMMIT_W-1:0]      commit_valid_o,
  output logic [COMMIT_W*IDX_W-1:0] commit_tag_o,
  output logic [COMMIT_W*5-1:0]    commit_dest_o,
  output logic [COMMIT_W*32-1:0]   commit_value_o,
  output logic [COMMIT_W*3-1:0]    commit_kind_o,
  output logic [IDX_W-1:0]         rob_head_o,
  output logic [IDX_W:0]           count_o
);

  localparam int N_W = $clog2(COMMIT_W + 1);

  rob_entry_t               ent_q [DEPTH];
  logic [IDX_W-1:0]         head_q, tail_q, rob_head_q;
  logic [IDX_W:0]           count_q;
  logic [COMMIT_W-1:0]      commit_valid_q;
  logic [COMMIT_W*IDX_W-1:0] commit_tag_q;
  logic [COMMIT_W*5-1:0]    commit_dest_q;
  logic [COMMIT_W*32-1:0]   commit_value_q;
  logic [COMMIT_W*3-1:0]    commit_kind_q;

  logic                     alloc_fire;
  logic [DEPTH-1:0]         wb_hit;
  logic [31:0]              wb_val [DEPTH];
  logic [DEPTH-1:0]         done_vec;
  logic [DEPTH*3-1:0]       kind_vec;
  logic [COMMIT_W-1:0]      retire;
  logic [N_W-1:0]           n_ret;
  logic [IDX_W-1:0]         slot_idx [COMMIT_W];
  logic [DEPTH-1:0]         retire_ent;

  assign alloc_tag_o = tail_q;
  assign rob_full_o  = count_q >= (IDX_W+1)'(DEPTH - FULL_MARGIN);
  assign alloc_fire  = alloc_valid_i && (count_q != (IDX_W+1)'(DEPTH));

  // Per-entry writeback resolution; later ports overwrite earlier ones so the
  // highest port index wins on a tag collision.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wb_hit[e] = 1'b0;
      wb_val[e] = '0;
    end
    for (int p = 0; p < NUM_WB; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_valid_i[p] && (wb_tag_i[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = wb_value_i[p*32 +: 32];
        end
      end
    end
  end

  // Lookup with same-cycle writeback bypass (only for live entries, matching
  // what the writeback itself would do).
  always_comb begin
    query_ready_o = '0;
    query_value_o = '0;
    for (int q = 0; q < 2; q++) begin
      if (wb_hit[query_tag_i[q*IDX_W +: IDX_W]] && ent_q[query_tag_i[q*IDX_W +: IDX_W]].valid) begin
        query_ready_o[q]         = 1'b1;
        query_value_o[q*32 +: 32] = wb_val[query_tag_i[q*IDX_W +: IDX_W]];
      end else begin
        query_ready_o[q]         = ent_q[query_tag_i[q*IDX_W +: IDX_W]].done;
        query_value_o[q*32 +: 32] = ent_q[query_tag_i[q*IDX_W +: IDX_W]].value;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      done_vec[e]         = ent_q[e].done;
      kind_vec[e*3 +: 3]  = ent_q[e].kind;
    end
  end

  rob_commit_select #(
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .COMMIT_W (COMMIT_W),
    .N_W      (N_W)
  ) u_sel (
    .head_i   (head_q),
    .count_i  (count_q),
    .done_i   (done_vec),
    .kind_i   (kind_vec),
    .retire_o (retire),
    .n_o      (n_ret)
  );

  always_comb begin
    retire_ent = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k] = head_q + IDX_W'(k);
      if (retire[k]) retire_ent[slot_idx[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rob_head_q     <= '0;
      commit_valid_q <= '0;
      commit_tag_q   <= '0;
      commit_dest_q  <= '0;
      commit_value_q <= '0;
      commit_kind_q  <= '0;
    end else if (rdy_i) begin
      rob_head_q <= head_q;
      if (flush_i) begin
        for (int e = 0; e < DEPTH; e++) begin
          ent_q[e].valid <= 1'b0;
          ent_q[e].done  <= 1'b0;
        end
        head_q         <= '0;
        tail_q         <= '0;
        count_q        <= '0;
        commit_valid_q <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wb_hit[e] && ent_q[e].valid) begin
            ent_q[e].done  <= 1'b1;
            ent_q[e].value <= wb_val[e];
          end
          if (retire_ent[e]) ent_q[e].valid <= 1'b0;
          // The tail entry can only be live when count==DEPTH, and then
          // alloc_fire is low, so this never collides with wb/retire.
          if (alloc_fire && (tail_q == IDX_W'(e))) begin
            ent_q[e].valid <= 1'b1;
            ent_q[e].done  <= alloc_value_valid_i;
            ent_q[e].kind  <= alloc_kind_i;
            ent_q[e].dest  <= alloc_dest_i;
            ent_q[e].value <= alloc_value_i;
          end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
          commit_valid_q[k] <= retire[k];
          if (retire[k]) begin
            commit_tag_q[k*IDX_W +: IDX_W] <= slot_idx[k];
            commit_dest_q[k*5 +: 5]        <= ent_q[slot_idx[k]].dest;
            commit_value_q[k*32 +: 32]     <= ent_q[slot_idx[k]].value;
            commit_kind_q[k*3 +: 3]        <= ent_q[slot_idx[k]].kind;
          end
        end
        head_q  <= head_q + IDX_W'(n_ret);
        tail_q  <= tail_q + IDX_W'(alloc_fire);
        count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(n_ret);
      end
    end
  end

  assign commit_valid_o = commit_valid_q;
  assign commit_tag_o   = commit_tag_q;
  assign commit_dest_o  = commit_dest_q;
  assign commit_value_o = commit_value_q;
  assign commit_kind_o  = commit_kind_q;
  assign rob_head_o     = rob_head_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench: two instances (COMMIT_W=2 and COMMIT_W=1) share stimulus;
// each has its own expected-commit queue checked by a negedge monitor.
module tb_rob_multi_commit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rdy;
  logic         alloc_valid;
  logic [4:0]   alloc_dest;
  logic [2:0]   alloc_kind;
  logic         alloc_vv;
  logic [31:0]  alloc_value;
  logic [3:0]   wb_valid;
  logic [15:0]  wb_tag;
  logic [127:0] wb_value;
  logic [7:0]   query_tag;
  logic         flush;

  logic [3:0]   a_atag, b_atag;
  logic         a_full, b_full;
  logic [1:0]   a_qrdy, b_qrdy;
  logic [63:0]  a_qval, b_qval;
  logic [1:0]   a_cv;
  logic [7:0]   a_ctag;
  logic [9:0]   a_cdest;
  logic [63:0]  a_cval;
  logic [5:0]   a_ckind;
  logic [0:0]   b_cv;
  logic [3:0]   b_ctag;
  logic [4:0]   b_cdest;
  logic [31:0]  b_cval;
  logic [2:0]   b_ckind;
  logic [3:0]   a_head, b_head;
  logic [4:0]   a_count, b_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [2:0]  kind;
    int          slot;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  rob_multi_commit #(.COMMIT_W(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy),
    .alloc_valid_i(alloc_valid), .alloc_dest_i(alloc_dest), .alloc_kind_i(alloc_kind),
    .alloc_value_valid_i(alloc_vv), .alloc_value_i(alloc_value),
    .alloc_tag_o(a_atag), .rob_full_o(a_full),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_value_i(wb_value),
    .query_tag_i(query_tag), .query_ready_o(a_qrdy), .query_value_o(a_qval),
    .flush_i(flush),
    .commit_valid_o(a_cv), .commit_tag_o(a_ctag), .commit_dest_o(a_cdest),
    .commit_value_o(a_cval), .commit_kind_o(a_ckind),
    .rob_head_o(a_head), .count_o(a_count)
  );

  rob_multi_commit #(.COMMIT_W(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy),
    .alloc_valid_i(alloc_valid), .alloc_dest_i(alloc_dest), .alloc_kind_i(alloc_kind),
    .alloc_value_valid_i(alloc_vv), .alloc_value_i(alloc_value),
    .alloc_tag_o(b_atag), .rob_full_o(b_full),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_value_i(wb_value),
    .query_tag_i(query_tag), .query_ready_o(b_qrdy), .query_value_o(b_qval),
    .flush_i(flush),
    .commit_valid_o(b_cv), .commit_tag_o(b_ctag), .commit_dest_o(b_cdest),
    .commit_value_o(b_cval), .commit_kind_o(b_ckind),
    .rob_head_o(b_head), .count_o(b_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Commit monitors: every retirement must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (a_cv[k]) begin
          total++;
          if (qa.size() == 0) begin
            bad++;
            $display("FAIL a_unexpected slot=%0d tag=%0d actual=commit required=none", k, a_ctag[k*4 +: 4]);
          end else begin
            ea = qa.pop_front();
            if (a_ctag[k*4 +: 4] !== ea.tag || a_cdest[k*5 +: 5] !== ea.dest ||
                a_cval[k*32 +: 32] !== ea.value || a_ckind[k*3 +: 3] !== ea.kind || k != ea.slot) begin
              bad++;
              $display("FAIL a_commit actual slot=%0d tag=%0d dest=%0d val=%0h kind=%0d required slot=%0d tag=%0d dest=%0d val=%0h kind=%0d",
                       k, a_ctag[k*4 +: 4], a_cdest[k*5 +: 5], a_cval[k*32 +: 32], a_ckind[k*3 +: 3],
                       ea.slot, ea.tag, ea.dest, ea.value, ea.kind);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_cv[0]) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected tag=%0d actual=commit required=none", b_ctag);
      end else begin
        eb = qb.pop_front();
        if (b_ctag !== eb.tag || b_cdest !== eb.dest || b_cval !== eb.value || b_ckind !== eb.kind) begin
          bad++;
          $display("FAIL b_commit actual tag=%0d dest=%0d val=%0h kind=%0d required tag=%0d dest=%0d val=%0h kind=%0d",
                   b_ctag, b_cdest, b_cval, b_ckind, eb.tag, eb.dest, eb.value, eb.kind);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; alloc_valid = 1'b0; alloc_dest = '0; alloc_kind = '0;
    alloc_vv = 1'b0; alloc_value = '0; wb_valid = '0; wb_tag = '0;
    wb_value = '0; query_tag = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [3:0] tag, input logic [4:0] dest, input logic [31:0] val,
                      input logic [2:0] kind, input int slot_a);
    exp_t e;
    e.tag = tag; e.dest = dest; e.value = val; e.kind = kind; e.slot = slot_a;
    qa.push_back(e);
    e.slot = 0;
    qb.push_back(e);
  endtask

  task automatic alloc(input logic [4:0] dest, input logic [2:0] kind,
                       input logic vv, input logic [31:0] val);
    alloc_valid = 1'b1; alloc_dest = dest; alloc_kind = kind; alloc_vv = vv; alloc_value = val;
    step();
    alloc_valid = 1'b0; alloc_vv = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [3:0] tag, input logic [31:0] val);
    wb_valid[p] = 1'b1;
    wb_tag[p*4 +: 4] = tag;
    wb_value[p*32 +: 32] = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset_cv", a_cv, 0);
    check("reset_count", a_count, 0);
    check("reset_tag", a_atag, 0);
    check("reset_full", a_full, 0);
    check("reset_head", a_head, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a commit.
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 3'd0, 1'b0, 32'h0);
    check("mid_count5", a_count, 5);
    set_wb(0, 4'd0, 32'h55);
    step();
    wb_valid = '0;
    step();
    check("mid_cv_before", a_cv, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("mid_cv_async", a_cv, 0);
    check("mid_count_async", a_count, 0);
    check("mid_b_cv_async", b_cv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_tag_after", a_atag, 0);

    // rdy low freezes everything.
    do_reset();
    rdy = 1'b0;
    alloc_valid = 1'b1; alloc_vv = 1'b1; alloc_value = 32'hDEAD;
    step();
    step();
    check("rdy_count", a_count, 0);
    check("rdy_tag", a_atag, 0);
    idle_inputs();

    // Fill up to the full threshold and beyond.
    do_reset();
    for (int i = 0; i < 12; i++) alloc(5'd7, 3'd0, 1'b0, 32'h0);
    check("fill_count12", a_count, 12);
    check("fill_full12", a_full, 0);
    alloc(5'd7, 3'd0, 1'b0, 32'h0);
    check("fill_count13", a_count, 13);
    check("fill_full13", a_full, 1);
    for (int i = 0; i < 3; i++) alloc(5'd7, 3'd0, 1'b0, 32'h0);
    check("fill_count16", a_count, 16);
    check("fill_tag16", a_atag, 0);
    alloc(5'd7, 3'd0, 1'b0, 32'h0);
    check("fill_drop_count", a_count, 16);
    check("fill_drop_tag", a_atag, 0);

    // Wrap: 20 precomputed entries, one per cycle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("wrap_tag%0d", i), a_atag, 64'(i % 16));
      push(4'(i % 16), 5'((i + 1) % 32), 32'h1000 + 32'(i), 3'd0, 0);
      alloc_valid = 1'b1; alloc_vv = 1'b1; alloc_kind = 3'd0;
      alloc_dest = 5'((i + 1) % 32); alloc_value = 32'h1000 + 32'(i);
      step();
    end
    idle_inputs();
    repeat (4) step();
    check("wrap_count", a_count, 0);
    check("wrap_head", a_head, 4);
    check("wrap_drain_a", 64'(qa.size()), 0);
    check("wrap_drain_b", 64'(qb.size()), 0);

    // Dual commit with a branch in slot 1.
    do_reset();
    alloc(5'd1, 3'd0, 1'b0, 32'h0);
    alloc(5'd0, 3'd1, 1'b0, 32'h0);
    alloc(5'd3, 3'd0, 1'b0, 32'h0);
    push(4'd0, 5'd1, 32'hA0, 3'd0, 0);
    push(4'd1, 5'd0, 32'hA1, 3'd1, 1);
    push(4'd2, 5'd3, 32'hA2, 3'd0, 0);
    set_wb(0, 4'd0, 32'hA0);
    set_wb(1, 4'd1, 32'hA1);
    set_wb(2, 4'd2, 32'hA2);
    step();
    wb_valid = '0;
    repeat (5) step();
    check("dual_count_a", a_count, 0);
    check("dual_count_b", b_count, 0);

    // Writeback collision and query bypass.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(10 + i), 3'd0, 1'b0, 32'h0);
    set_wb(0, 4'd4, 32'h11);
    set_wb(3, 4'd4, 32'h33);
    query_tag = {4'd3, 4'd4};
    #1;
    check("wbc_qrdy_bypass", a_qrdy[0], 1);
    check("wbc_qval_bypass", a_qval[31:0], 32'h33);
    check("wbc_qrdy_other", a_qrdy[1], 0);
    step();
    wb_valid = '0;
    #1;
    check("wbc_qrdy_reg", a_qrdy[0], 1);
    check("wbc_qval_reg", a_qval[31:0], 32'h33);
    for (int i = 0; i < 4; i++) push(4'(i), 5'(10 + i), 32'h20 + 32'(i), 3'd0, i % 2);
    push(4'd4, 5'd14, 32'h33, 3'd0, 0);
    for (int i = 0; i < 4; i++) set_wb(i, 4'(i), 32'h20 + 32'(i));
    step();
    wb_valid = '0;
    query_tag = '0;
    repeat (6) step();
    check("wbc_count", a_count, 0);

    // Flush together with alloc, writeback and a pending head commit.
    do_reset();
    alloc(5'd2, 3'd0, 1'b0, 32'h0);
    alloc(5'd3, 3'd0, 1'b0, 32'h0);
    set_wb(0, 4'd0, 32'h77);
    step();
    wb_valid = '0;
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_vv = 1'b1; alloc_dest = 5'd9; alloc_value = 32'h99;
    set_wb(1, 4'd1, 32'h88);
    step();
    idle_inputs();
    check("flush_count", a_count, 0);
    check("flush_cv", a_cv, 0);
    check("flush_tag", a_atag, 0);
    check("flush_b_cv", b_cv, 0);
    step();
    check("flush_cv_next", a_cv, 0);
    check("flush_realloc_tag", a_atag, 0);
    push(4'd0, 5'd6, 32'h66, 3'd0, 0);
    alloc(5'd6, 3'd0, 1'b1, 32'h66);
    repeat (3) step();
    check("flush_end_count", a_count, 0);

    check("final_drain_a", 64'(qa.size()), 0);
    check("final_drain_b", 64'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
